// File: rtl/mux_arb.sv
`default_nettype none
// ============================================================================
// mux_arb : N-channel valid/ready arbiter feeding a one-entry registered output
//           stage (fixed-priority or round-robin selection).
// Revision : 1.0
// ============================================================================
module mux_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SELW-1:0]            out_sel,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [SELW-1:0]     ptr_q, ptr_d;

  logic                can_accept;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic [SELW-1:0]     grant_idx;
  logic [WIDTH-1:0]    grant_data;

  // Search starts at ptr (round-robin) or 0 (fixed) and wraps once round.
  always_comb begin : arbiter
    int          base;
    int          idx;
    logic [SELW-1:0] idx_s;
    base       = 0;
    idx        = 0;
    idx_s      = '0;
    can_accept = !out_valid_q || out_ready;
    req        = (can_accept && !rst) ? in_valid : '0;
    if (RR_MODE != 0) begin
      base = int'(ptr_q);
    end
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      idx = base + off;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      idx_s = SELW'(idx);
      if (!grant_any && req[idx_s]) begin
        grant_any    = 1'b1;
        grant_idx    = idx_s;
        grant[idx_s] = 1'b1;
      end
    end
  end

  // Grant is one-hot, so an AND-OR mux selects the winning slice.
  always_comb begin : data_mux
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        grant_data = grant_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : next_state
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (grant_any) begin
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = grant;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb.sv
`default_nettype none
// ============================================================================
// tb_mux_arb : self-checking bench for mux_arb, round-robin and fixed-priority
//              instances driven in parallel and compared to a behavioural model.
// Revision   : 1.0
// ============================================================================
module tb_mux_arb;
  localparam int W = 32;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0]   in_valid = '0;
  logic           out_ready = 1'b0;

  logic [C-1:0]   rr_in_ready, fx_in_ready;
  logic [W-1:0]   rr_out_data, fx_out_data;
  logic [1:0]     rr_out_sel, fx_out_sel;
  logic           rr_out_valid, fx_out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit          mv [2];
  logic [31:0] md [2];
  int          ms [2];
  int          mp [2];

  mux_arb #(.WIDTH(W), .CHANNELS(C), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  mux_arb #(.WIDTH(W), .CHANNELS(C), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fx_in_ready), .out_data(fx_out_data), .out_sel(fx_out_sel),
    .out_valid(fx_out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int model_grant(int m);
    int base;
    if (rst) return -1;
    if (mv[m] && !out_ready) return -1;
    base = (m == 0) ? mp[0] : 0;
    for (int off = 0; off < C; off++) begin
      if (in_valid[(base + off) % C]) return (base + off) % C;
    end
    return -1;
  endfunction

  function automatic logic [C-1:0] model_ready(int m);
    int g;
    g = model_grant(m);
    return (g >= 0) ? C'(1 << g) : '0;
  endfunction

  // Advances one rising edge (inputs held stable) and returns on the falling edge.
  task automatic tick();
    int g [2];
    for (int m = 0; m < 2; m++) g[m] = model_grant(m);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mv[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
      end else if (g[m] >= 0) begin
        mv[m] = 1; md[m] = in_data[g[m]*W +: W]; ms[m] = g[m]; mp[m] = (g[m] + 1) % C;
      end else if (mv[m] && out_ready) begin
        mv[m] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (rr_in_ready !== 4'b0000 || fx_in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_in_ready: rr=%b fx=%b expected 0000", rr_in_ready, fx_in_ready);
      end
      tick();
    end
    rst = 1'b0; in_valid = '0;
    n_tests++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h sel=%0d expected 0/0/0",
               rr_out_valid, rr_out_data, rr_out_sel);
    end
  endtask

  task automatic test_single_channel();
    out_ready = 1'b1; in_valid = 4'b0100; in_data[2*W +: W] = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (rr_in_ready !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_ready: got %b expected 0100", rr_in_ready);
      end
      tick();
      n_tests++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hDEADBEEF || rr_out_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL single_out: valid=%b data=%h sel=%0d expected 1/deadbeef/2",
                 rr_out_valid, rr_out_data, rr_out_sel);
      end
    end
    // Pointer should now sit at 3, so channel 3 wins a full request.
    in_valid = 4'b1111;
    #1;
    n_tests++;
    if (rr_in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_ptr: in_ready=%b expected 1000", rr_in_ready);
    end
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < C; i++) in_data[i*W +: W] = 32'h10 + i;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (rr_out_sel !== 2'(k % 4) || rr_out_data !== 32'h10 + (k % 4) || rr_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation[%0d]: sel=%0d data=%h expected sel=%0d data=%h",
                 k, rr_out_sel, rr_out_data, k % 4, 32'h10 + (k % 4));
      end
    end
  endtask

  task automatic test_fixed();
    out_ready = 1'b1; in_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (fx_in_ready !== 4'b0010) begin
        n_fail++;
        $display("FAIL fixed_ready: got %b expected 0010", fx_in_ready);
      end
      tick();
      n_tests++;
      if (fx_out_sel !== 2'd1 || fx_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fixed_sel: sel=%0d valid=%b expected 1/1", fx_out_sel, fx_out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1; in_valid = 4'b0001;
    in_data[0 +: W] = 32'hA5A5A5A5; in_data[W +: W] = 32'h12345678;
    tick();
    out_ready = 1'b0; in_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_tests++;
      if (rr_in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready: got %b expected 0000", rr_in_ready);
      end
      tick();
      n_tests++;
      if (rr_out_data !== 32'hA5A5A5A5 || rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold: data=%h valid=%b sel=%0d expected a5a5a5a5/1/0",
                 rr_out_data, rr_out_valid, rr_out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (rr_in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b expected 0010", rr_in_ready);
    end
    tick();
    n_tests++;
    if (rr_out_sel !== 2'd1 || rr_out_valid !== 1'b1 || rr_out_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bp_release_out: sel=%0d valid=%b data=%h expected 1/1/12345678",
               rr_out_sel, rr_out_valid, rr_out_data);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if (rr_out_valid !== 1'b0 || fx_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_valid: rr=%b fx=%b expected 0", rr_out_valid, fx_out_valid);
    end
    rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_tests++;
    if (rr_in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_grant: got %b expected 0001", rr_in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = C'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < C; i++) in_data[i*W +: W] = $urandom;
      #1;
      n_tests++;
      if (rr_in_ready !== model_ready(0) || fx_in_ready !== model_ready(1)) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: rr=%b fx=%b expected rr=%b fx=%b",
                 k, rr_in_ready, fx_in_ready, model_ready(0), model_ready(1));
      end
      tick();
      n_tests++;
      if (rr_out_valid !== mv[0] || rr_out_data !== md[0] || rr_out_sel !== 2'(ms[0])) begin
        n_fail++;
        $display("FAIL rand_rr_out[%0d]: v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                 k, rr_out_valid, rr_out_data, rr_out_sel, mv[0], md[0], ms[0]);
      end
      n_tests++;
      if (fx_out_valid !== mv[1] || fx_out_data !== md[1] || fx_out_sel !== 2'(ms[1])) begin
        n_fail++;
        $display("FAIL rand_fx_out[%0d]: v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                 k, fx_out_valid, fx_out_data, fx_out_sel, mv[1], md[1], ms[1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = '0; ms[m] = 0; mp[m] = 0;
    end
    @(negedge clk);
    tick();
    test_reset();
    test_single_channel();
    test_rotation();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
